// File: rtl/deserializing_pkg.sv
// Shared constants for the serial link: input FSM encodings and the default word width.
package deserializing_pkg;

    typedef logic [0:0] fsm_state_t;

    // Same 1-bit encoding as the serializer's WAITING/SENDING states
    localparam fsm_state_t IDLE = 1'b0;
    localparam fsm_state_t RECV = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deserializing.sv
// Serial-to-parallel receiver: LSB-first bit collection into WIDTH-bit words,
// held output register with valid/ready, and framing/overflow error pulses.
module deserializing
    import deserializing_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_error,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    fsm_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             word_done_reg;

    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             frame_error_reg;
    logic             overflow_reg;

    // Bits enter at the top and shift right, so after WIDTH bits the first
    // one sits in bit 0; stale bits of a discarded partial word fall off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            shift_reg       <= '0;
            word_done_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            word_done_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
            if (din_valid) begin
                shift_reg <= {din, shift_reg[WIDTH-1:1]};
                count_reg <= count_reg + CNT_W'(1);
                state_reg <= RECV;
                if (state_reg == RECV && count_reg == LAST_BIT) begin
                    word_done_reg <= 1'b1;
                end
            end else begin
                state_reg <= IDLE;
                count_reg <= '0;
                if (state_reg == RECV && count_reg != '0) begin
                    frame_error_reg <= 1'b1;
                end
            end
        end
    end

    // The completed word waits one edge in shift_reg; this read sees it
    // before the next word's first bit shifts in on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            overflow_reg <= 1'b0;
            if (word_done_reg) begin
                if (!dout_valid_reg || dout_ready) begin
                    dout_reg       <= shift_reg;
                    dout_valid_reg <= 1'b1;
                end else begin
                    overflow_reg <= 1'b1;
                end
            end else if (dout_valid_reg && dout_ready) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign dout        = dout_reg;
    assign dout_valid  = dout_valid_reg;
    assign frame_error = frame_error_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_deserializing.sv
// Self-checking bench for deserializing: directed scenarios plus randomized traffic
// against a queue-based behavioural model, compared every cycle.
module tb_deserializing;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_error;
    logic             overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    deserializing #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic             bits[$];
    logic [WIDTH-1:0] arrival_word = '0;
    bit               have_arrival = 0;
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_valid = 1'b0;
    logic             exp_ferr = 1'b0;
    logic             exp_ovf = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bits.delete();
            have_arrival = 0;
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            // word that completed on the previous edge reaches the output now
            exp_ovf = 1'b0;
            if (have_arrival) begin
                if (!exp_valid || dout_ready) begin
                    exp_dout  = arrival_word;
                    exp_valid = 1'b1;
                end else begin
                    exp_ovf = 1'b1;
                end
            end else if (exp_valid && dout_ready) begin
                exp_valid = 1'b0;
            end
            have_arrival = 0;
            exp_ferr = 1'b0;
            if (din_valid) begin
                bits.push_back(din);
                if (bits.size() == WIDTH) begin
                    for (int k = 0; k < WIDTH; k++) arrival_word[k] = bits[k];
                    have_arrival = 1;
                    bits.delete();
                end
            end else if (bits.size() != 0) begin
                exp_ferr = 1'b1;
                bits.delete();
            end
        end
    end

    // ---------------- per-cycle compare and capture ----------------
    typedef struct {
        logic [WIDTH-1:0] w;
        int               c;
    } cap_t;
    cap_t caps[$];

    always @(negedge clk) begin
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("frame_error", 32'(frame_error), 32'(exp_ferr));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            cap_t e;
            e.w = dout;
            e.c = cyc;
            caps.push_back(e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            din = w[k];
            din_valid = 1'b1;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        send_bits(w, WIDTH);
    endtask

    initial begin
        @(negedge clk);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_valid", 32'(dout_valid), 32'h0);
        #2 reset_n = 1'b1;

        // basic word
        dout_ready = 1'b1;
        send_word(8'hA5);
        @(negedge clk);
        din_valid = 1'b0;
        chk("basic_not_yet", 32'(dout_valid), 32'h0);
        @(negedge clk);
        chk("basic_valid", 32'(dout_valid), 32'h1);
        chk("basic_dout", 32'(dout), 32'hA5);
        @(negedge clk);
        chk("basic_one_cycle", 32'(dout_valid), 32'h0);

        // back-to-back words
        caps.delete();
        send_word(8'h3C);
        send_word(8'hC3);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_count", 32'(caps.size()), 32'd2);
        if (caps.size() == 2) begin
            chk("b2b_first", 32'(caps[0].w), 32'h3C);
            chk("b2b_second", 32'(caps[1].w), 32'hC3);
            chk("b2b_spacing", 32'(caps[1].c - caps[0].c), 32'd8);
        end

        // partial word
        caps.delete();
        send_bits(8'h0D, 5);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        chk("partial_ferr", 32'(frame_error), 32'h1);
        chk("partial_novalid", 32'(dout_valid), 32'h0);
        @(negedge clk);
        chk("partial_ferr_pulse", 32'(frame_error), 32'h0);
        send_word(8'hFF);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_after_count", 32'(caps.size()), 32'd1);
        if (caps.size() == 1) chk("partial_after_word", 32'(caps[0].w), 32'hFF);

        // overflow
        dout_ready = 1'b0;
        send_word(8'h12);
        send_word(8'h34);
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        chk("ovf_pulse", 32'(overflow), 32'h1);
        chk("ovf_held", 32'(dout), 32'h12);
        chk("ovf_valid", 32'(dout_valid), 32'h1);
        dout_ready = 1'b1;
        @(negedge clk);
        chk("ovf_drained", 32'(dout_valid), 32'h0);
        chk("ovf_dout_kept", 32'(dout), 32'h12);
        dout_ready = 1'b0;

        // accept and complete on the same edge
        send_word(8'h12);
        send_word(8'h34);
        @(negedge clk);
        din_valid = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("simul_dout", 32'(dout), 32'h34);
        chk("simul_valid", 32'(dout_valid), 32'h1);
        chk("simul_noovf", 32'(overflow), 32'h0);
        @(negedge clk);
        chk("simul_accepted", 32'(dout_valid), 32'h0);
        dout_ready = 1'b0;

        // asynchronous reset mid-word
        send_bits(8'h0F, 4);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_valid", 32'(dout_valid), 32'h0);
        chk("arst_ferr", 32'(frame_error), 32'h0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        din_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("arst_no_ferr", 32'(frame_error), 32'h0);
        caps.delete();
        dout_ready = 1'b1;
        send_word(8'h81);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_after_count", 32'(caps.size()), 32'd1);
        if (caps.size() == 1) chk("arst_after_word", 32'(caps[0].w), 32'h81);

        // randomized traffic, occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            din        = 1'($urandom_range(0, 1));
            din_valid  = ($urandom_range(0, 19) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializing.md
Name: deserializing

Overview:
- Receive-side counterpart of the framing/encoding serializer.
- Collects a 1-bit serial stream, qualified by a per-bit valid, into WIDTH-bit words, least-significant bit first.
- Presents each completed word on a held output register with a valid/ready handshake toward the framing decoder.
- Flags partial words (valid dropped mid-word) and words lost because the output register was still occupied.

Parameters:
- WIDTH, 8: word width in bits. Must be a power of 2 and ≥2. The bit counter is clog2(WIDTH) bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit; sampled only when din_valid=1.
- din_valid  input  1  bit qualifier; high for every bit of a word, back-to-back words allowed.
- dout  output  WIDTH  assembled word; stable while dout_valid=1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready at a rising edge.
- frame_error  output  1  one-cycle pulse: partial word discarded.
- overflow  output  1  one-cycle pulse: completed word dropped because the output register was full.

Behaviour:
- Reset (async, reset_n=0):
  - shift register=0, bit count=0, input FSM=IDLE.
  - dout=0, dout_valid=0, frame_error=0, overflow=0.
  - Takes effect immediately, including mid-word; the partial word is lost silently (no frame_error).
- Input FSM, states IDLE and RECV:
  - IDLE: count=0. din_valid=1 -> capture din into bit 0, count=1, go to RECV.
  - RECV, din_valid=1: capture din into bit[count], count+1.
  - RECV, din_valid=1 and count=WIDTH-1: word complete. Count wraps to 0 and the FSM stays in RECV, so the next word can start on the very next cycle.
  - RECV, din_valid=0 with count≠0: discard partial bits, count=0, go to IDLE, frame_error=1 on the following cycle for exactly one cycle.
  - RECV, din_valid=0 with count=0 (word boundary): go to IDLE, no error.
- Bit ordering: the k-th valid bit of a word (k=0 first) lands in dout[k].
- Latency: dout_valid rises on the rising edge after the edge that samples the last bit; dout equals the word from that same edge.
- Output register:
  - Word complete and (dout_valid=0, or dout_valid & dout_ready at the same edge) -> load dout, dout_valid=1.
  - Word complete and dout_valid=1 and dout_ready=0 -> new word dropped; dout and dout_valid are unchanged; overflow=1 for one cycle.
  - dout_valid & dout_ready with no word completing -> dout_valid=0; dout keeps its last value.
  - dout_valid never drops without a handshake.
- frame_error and overflow are registered pulses. They are independent and may assert in the same cycle.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - input FSM state encodings IDLE=0, RECV=1, matching the serializer's WAITING/SENDING 1-bit encoding.
  - default WIDTH constant shared with the serializer.
- Sub-module: none. The block is small; keep the input FSM, counter, shift register and output register flat in one module.

Test Plan:
- Basic word: dout_ready=1, din_valid=1 for 8 cycles, din=1,0,1,0,0,1,0,1 -> dout=8'hA5, dout_valid high exactly 1 cycle, one edge after the 8th bit; no flags.
- Back-to-back: din_valid=1 for 16 cycles carrying 8'h3C then 8'hC3, dout_ready=1 -> dout_valid pulses 8 cycles apart with 8'h3C then 8'hC3; frame_error=0.
- Partial word: 5 valid bits then din_valid=0 -> frame_error 1-cycle pulse, dout_valid stays 0. Then 8 bits of 1 -> dout=8'hFF.
- Overflow: dout_ready=0, send 8'h12 then 8'h34 back-to-back -> dout=8'h12 held, overflow pulses as 8'h34 completes. Then dout_ready=1 for 1 cycle -> dout_valid=0, dout stays 8'h12.
- Simultaneous accept/complete: dout holding 8'h12, dout_ready=1 on the edge 8'h34 completes -> dout=8'h34, dout_valid stays 1, overflow=0.
- Reset mid-word: 4 valid bits, pulse reset_n low asynchronously between edges -> all outputs 0 immediately, no frame_error. Then send 8'h81 -> dout=8'h81.
